// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: queues TX bytes (with a per-byte rx_discard flag), issues them one
// at a time to a byte-level SPI engine and collects the returned MISO bytes in an RX FIFO.
// Optional watchdog: define SPI_SEQ_TIMEOUT_EN to enable the per-byte timeout counter.
module spi_byte_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic          rx_discard,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level,
  output logic          busy,
  output logic          err_timeout,
  input  logic          err_clr,
  output logic [7:0]    spi_byte_send,
  output logic          spi_send_byte,
  output logic          spi_receive_byte,
  input  logic [7:0]    spi_byte_receive,
  input  logic          spi_system_idle
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [8:0]      tx_mem_q [FIFO_DEPTH];
  logic [7:0]      rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [LW-1:0]   tx_lvl_q, rx_lvl_q;
  logic [7:0]      byte_q;
  logic            disc_q;
  logic            tx_push, tx_pop, rx_push, rx_pop, load, timeout;
  logic [8:0]      tx_head;

  assign tx_head          = tx_mem_q[tx_rd_q];
  assign tx_ready         = (tx_lvl_q != LW'(FIFO_DEPTH));
  assign rx_valid         = (rx_lvl_q != '0);
  assign rx_data          = rx_mem_q[rx_rd_q];
  assign tx_level         = tx_lvl_q;
  assign rx_level         = rx_lvl_q;
  assign tx_push          = tx_valid & tx_ready;
  assign rx_pop           = rx_valid & rx_ready;
  assign spi_send_byte    = (state_q == ISSUE);
  assign spi_receive_byte = 1'b0;
  assign spi_byte_send    = byte_q;
  assign busy             = (state_q != IDLE) || (tx_lvl_q != '0);

  // FIFO storage: data only, no reset needed since levels gate every read
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= {rx_discard, tx_data};
    if (rx_push) rx_mem_q[rx_wr_q] <= spi_byte_receive;
  end

  // FIFO pointers, occupancy, issued byte and its latched discard flag
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_lvl_q <= '0;
      rx_lvl_q <= '0;
      byte_q   <= '0;
      disc_q   <= 1'b0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      tx_lvl_q <= tx_lvl_q + LW'(tx_push) - LW'(tx_pop);
      rx_lvl_q <= rx_lvl_q + LW'(rx_push) - LW'(rx_pop);
      if (load) begin
        byte_q <= tx_head[7:0];
        disc_q <= tx_head[8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          cnt_hit;

  // cnt_q counts wait cycles since ISSUE; hitting the limit on the last one aborts the byte
  assign cnt_hit     = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  // Watchdog next state: a new timeout takes priority over err_clr
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ISSUE)
      cnt_d = '0;
    else if ((state_q == WAIT_START) || (state_q == WAIT_DONE))
      cnt_d = cnt_q + TW'(1);
    if (timeout)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic cnt_hit;
  logic unused_err_clr;
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign cnt_hit        = 1'b0;
  assign err_timeout    = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  // FSM next state: one byte in flight; RX space is reserved before issue
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    load    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if ((tx_lvl_q != '0) && spi_system_idle &&
            (tx_head[8] || (rx_lvl_q != LW'(FIFO_DEPTH)))) begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        tx_pop  = 1'b1;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (cnt_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (!spi_system_idle) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cnt_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (spi_system_idle) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rx_push = !disc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
